// File: rtl/weight_buffer_ctrl.sv
// weight_buffer_ctrl: sequences LOAD/READ commands onto a 16x8 weight SRAM
//   Ports: clk, reset_n (async active-low);
//     command in: load_start, rd_start, cmd_base, cmd_len;
//     host load stream: load_valid, load_data, load_ready;
//     compute stream out: out_valid, out_data, out_last;
//     status: busy, done, cmd_err;
//     SRAM: sram_csb, sram_web, sram_addr, sram_din (out), sram_dout (in).
module weight_buffer_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              cmd_err,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);
    typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              cmd_err_q, cmd_err_d;
    logic              any_start, len_ok, beat, last;

    assign any_start = load_start || rd_start;
    assign len_ok    = (cmd_len != '0) && (cmd_len <= CNT_W'(DEPTH));
    assign beat      = (state_q == LOAD) && load_valid;
    assign last      = (rem_q == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // Read data returns one cycle after issue, so the stream flags are the
    // issue-cycle conditions delayed by one flop. done is registered the same
    // way, which lines it up with out_last for READ and lands it one cycle
    // after the final beat for LOAD.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        cmd_err_d   = any_start;
        out_valid_d = (state_q == READ);
        out_last_d  = (state_q == READ) && last;
        case (state_q)
            IDLE: begin
                cmd_err_d = (load_start && rd_start) || (any_start && !len_ok);
                if (any_start && len_ok) begin
                    state_d = load_start ? LOAD : READ;
                    addr_d  = cmd_base;
                    rem_d   = cmd_len;
                end
            end
            LOAD: begin
                if (beat) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - CNT_W'(1);
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - CNT_W'(1);
                if (last) begin
                    state_d = DRAIN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == LOAD);
        busy       = (state_q != IDLE);
        sram_csb   = !(beat || (state_q == READ));
        sram_web   = !beat;
        sram_addr  = addr_q;
        sram_din   = beat ? load_data : '0;
        out_valid  = out_valid_q;
        out_last   = out_last_q;
        out_data   = out_valid_q ? sram_dout : '0;
        done       = done_q;
        cmd_err    = cmd_err_q;
    end
endmodule
